// File: rtl/wb_scheduler_if.sv
// Handshake bundle for the writeback scheduler: issue port, two writeback
// requesters, the registered regfile write port and the busy scoreboard.
interface wb_scheduler_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [4:0]      rs1_num;
    logic [4:0]      rs2_num;
    logic            issue_ready;

    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;

    logic            lsu_valid;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;

    logic            w_enable;
    logic [4:0]      rd_num;
    logic [XLEN-1:0] rd_data;
    logic [NREG-1:0] busy;

    modport master (
        output issue_valid, issue_rd, rs1_num, rs2_num,
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  issue_ready, alu_ready, lsu_ready,
        input  w_enable, rd_num, rd_data, busy
    );

    modport slave (
        input  issue_valid, issue_rd, rs1_num, rs2_num,
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output issue_ready, alu_ready, lsu_ready,
        output w_enable, rd_num, rd_data, busy
    );
endinterface

// File: rtl/wb_scheduler.sv
// Writeback scheduler: round-robin ALU/LSU arbitration into a single registered
// regfile write port, plus a busy scoreboard that stalls RAW/WAW hazards at issue.
module wb_scheduler #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          rst,
    wb_scheduler_if.slave bus
);
    localparam int RW = 5;

    // 1 = LSU won the last accepted transfer; reset value lets the ALU win first.
    logic            last_lsu_reg;
    logic            last_lsu_next;
    logic            grant_alu;
    logic            grant_lsu;
    logic            accept;
    logic            issue_fire;
    logic [RW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;

    logic            w_enable_reg;
    logic [RW-1:0]   rd_num_reg;
    logic [XLEN-1:0] rd_data_reg;
    logic [NREG-1:0] busy_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_lsu_reg <= 1'b1;
        end else begin
            last_lsu_reg <= last_lsu_next;
        end
    end

    always_comb begin
        last_lsu_next = last_lsu_reg;
        if (accept) begin
            last_lsu_next = grant_lsu;
        end
    end

    always_comb begin
        grant_alu = bus.alu_valid && (!bus.lsu_valid || last_lsu_reg);
        grant_lsu = bus.lsu_valid && !grant_alu;
        accept    = grant_alu || grant_lsu;
        sel_rd    = grant_lsu ? bus.lsu_rd   : bus.alu_rd;
        sel_data  = grant_lsu ? bus.lsu_data : bus.alu_data;
    end

    // rd=0 transfers are consumed but never reach the regfile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_enable_reg <= 1'b0;
            rd_num_reg   <= '0;
            rd_data_reg  <= '0;
        end else if (accept) begin
            w_enable_reg <= (sel_rd != '0);
            rd_num_reg   <= sel_rd;
            rd_data_reg  <= sel_data;
        end else begin
            w_enable_reg <= 1'b0;
        end
    end

    // busy[0] never sets, so x0 sources and destinations never stall.
    assign issue_fire = bus.issue_valid && bus.issue_ready;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_reg[gi] = 1'b0;
            end else begin : g_bit
                logic set_bit;
                logic clr_bit;
                assign set_bit = issue_fire && (bus.issue_rd == RW'(gi));
                assign clr_bit = w_enable_reg && (rd_num_reg == RW'(gi));
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        busy_reg[gi] <= 1'b0;
                    end else if (set_bit) begin
                        busy_reg[gi] <= 1'b1;
                    end else if (clr_bit) begin
                        busy_reg[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        bus.issue_ready = !(busy_reg[bus.rs1_num] || busy_reg[bus.rs2_num] ||
                            busy_reg[bus.issue_rd]);
        bus.alu_ready   = grant_alu;
        bus.lsu_ready   = grant_lsu;
        bus.w_enable    = w_enable_reg;
        bus.rd_num      = rd_num_reg;
        bus.rd_data     = rd_data_reg;
        bus.busy        = busy_reg;
    end
endmodule

// File: tb/tb_wb_scheduler.sv
// Self-checking bench for wb_scheduler: directed scenarios plus a randomized
// run against a behavioural scoreboard/arbiter model.
module tb_wb_scheduler;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    wb_scheduler_if #(.XLEN(32), .NREG(32)) bus ();

    wb_scheduler #(.XLEN(32), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who won last contention, pending-write set, last write.
    bit          m_lsu_won_last;
    logic [31:0] m_busy;
    bit          m_wen;
    logic [4:0]  m_rdn;
    logic [31:0] m_rdd;

    task automatic model_reset();
        m_lsu_won_last = 1'b1;
        m_busy = '0;
        m_wen  = 1'b0;
        m_rdn  = '0;
        m_rdd  = '0;
    endtask

    function automatic bit model_issue_ready();
        bit hz;
        hz = (bus.rs1_num != 0 && m_busy[bus.rs1_num]) ||
             (bus.rs2_num != 0 && m_busy[bus.rs2_num]) ||
             (bus.issue_rd != 0 && m_busy[bus.issue_rd]);
        return !hz;
    endfunction

    function automatic bit model_alu_wins();
        if (!bus.alu_valid) return 1'b0;
        if (!bus.lsu_valid) return 1'b1;
        return m_lsu_won_last;
    endfunction

    function automatic bit model_lsu_wins();
        if (!bus.lsu_valid) return 1'b0;
        if (!bus.alu_valid) return 1'b1;
        return !m_lsu_won_last;
    endfunction

    // Advance the model across one rising edge using the inputs present at it.
    task automatic model_edge();
        bit ga, gl, fire;
        ga   = model_alu_wins();
        gl   = model_lsu_wins();
        fire = bus.issue_valid && model_issue_ready();
        if (m_wen) m_busy[m_rdn] = 1'b0;
        if (fire && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
        if (ga || gl) begin
            m_lsu_won_last = gl;
            m_rdn = gl ? bus.lsu_rd : bus.alu_rd;
            m_rdd = gl ? bus.lsu_data : bus.alu_data;
            m_wen = (m_rdn != 0);
        end else begin
            m_wen = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        bus.issue_valid = 0; bus.issue_rd = 0; bus.rs1_num = 0; bus.rs2_num = 0;
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.alu_valid = 1; bus.lsu_valid = 1; bus.alu_rd = 4; bus.lsu_rd = 6;
        bus.issue_rd = 3; bus.rs1_num = 4; bus.rs2_num = 5;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.w_enable !== 1'b0 || bus.rd_num !== 5'd0 || bus.rd_data !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_wport: got w_enable=%b rd_num=%0d rd_data=%h, want 0/0/0",
                     bus.w_enable, bus.rd_num, bus.rd_data);
        end
        vectors++;
        if (bus.busy !== 32'd0 || bus.issue_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_busy: got busy=%h issue_ready=%b, want 0/1", bus.busy, bus.issue_ready);
        end
        vectors++;
        if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_first_grant: got alu_ready=%b lsu_ready=%b, want 1/0",
                     bus.alu_ready, bus.lsu_ready);
        end
        #3;
        idle_inputs();
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_single_alu();
        do_reset();
        bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF;
        #1;
        vectors++;
        if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_accept: got alu_ready=%b lsu_ready=%b, want 1/0", bus.alu_ready, bus.lsu_ready);
        end
        @(posedge clk);
        #1;
        bus.alu_valid = 0;
        vectors++;
        if (bus.w_enable !== 1'b1 || bus.rd_num !== 5'd5 || bus.rd_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL alu_write: got w_enable=%b rd_num=%0d rd_data=%h, want 1/5/deadbeef",
                     bus.w_enable, bus.rd_num, bus.rd_data);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.w_enable !== 1'b0 || bus.rd_num !== 5'd5 || bus.rd_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL alu_hold: got w_enable=%b rd_num=%0d rd_data=%h, want 0/5/deadbeef",
                     bus.w_enable, bus.rd_num, bus.rd_data);
        end
        $display("test_single_alu done");
    endtask

    task automatic test_round_robin();
        bit exp_alu;
        do_reset();
        bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_data = 32'h1111_0001;
        bus.lsu_valid = 1; bus.lsu_rd = 2; bus.lsu_data = 32'h2222_0002;
        for (int i = 0; i < 4; i++) begin
            exp_alu = (i % 2 == 0);
            #1;
            vectors++;
            if (bus.alu_ready !== exp_alu || bus.lsu_ready !== !exp_alu) begin
                miscompares++;
                $display("FAIL rr_grant[%0d]: got alu_ready=%b lsu_ready=%b, want %b/%b",
                         i, bus.alu_ready, bus.lsu_ready, exp_alu, !exp_alu);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (bus.w_enable !== 1'b1 || bus.rd_num !== (exp_alu ? 5'd1 : 5'd2) ||
                bus.rd_data !== (exp_alu ? 32'h1111_0001 : 32'h2222_0002)) begin
                miscompares++;
                $display("FAIL rr_write[%0d]: got w_enable=%b rd_num=%0d rd_data=%h, want rd_num=%0d",
                         i, bus.w_enable, bus.rd_num, bus.rd_data, exp_alu ? 1 : 2);
            end
        end
        idle_inputs();
        $display("test_round_robin done");
    endtask

    task automatic test_raw();
        do_reset();
        bus.issue_valid = 1; bus.issue_rd = 7;
        #1;
        vectors++;
        if (bus.issue_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL raw_first_issue: got issue_ready=%b, want 1", bus.issue_ready);
        end
        @(posedge clk);
        #1;
        bus.issue_rd = 8; bus.rs1_num = 7;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (bus.issue_ready !== 1'b0 || bus.busy[7] !== 1'b1) begin
                miscompares++;
                $display("FAIL raw_stall[%0d]: got issue_ready=%b busy7=%b, want 0/1",
                         i, bus.issue_ready, bus.busy[7]);
            end
            @(posedge clk);
            #1;
        end
        bus.alu_valid = 1; bus.alu_rd = 7; bus.alu_data = 32'h0000_0777;
        @(posedge clk);
        #1;
        bus.alu_valid = 0;
        vectors++;
        if (bus.w_enable !== 1'b1 || bus.rd_num !== 5'd7 || bus.issue_ready !== 1'b0 || bus.busy[7] !== 1'b1) begin
            miscompares++;
            $display("FAIL raw_commit_cycle: got w_enable=%b rd_num=%0d issue_ready=%b busy7=%b, want 1/7/0/1",
                     bus.w_enable, bus.rd_num, bus.issue_ready, bus.busy[7]);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.issue_ready !== 1'b1 || bus.busy[7] !== 1'b0) begin
            miscompares++;
            $display("FAIL raw_release: got issue_ready=%b busy7=%b, want 1/0", bus.issue_ready, bus.busy[7]);
        end
        idle_inputs();
        $display("test_raw done");
    endtask

    task automatic test_zero_reg();
        do_reset();
        bus.issue_valid = 1; bus.issue_rd = 0; bus.rs1_num = 0; bus.rs2_num = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (bus.issue_ready !== 1'b1 || bus.busy !== 32'd0) begin
                miscompares++;
                $display("FAIL zero_issue[%0d]: got issue_ready=%b busy=%h, want 1/0",
                         i, bus.issue_ready, bus.busy);
            end
            @(posedge clk);
            #1;
        end
        bus.issue_valid = 0;
        bus.lsu_valid = 1; bus.lsu_rd = 0; bus.lsu_data = 32'h1234_5678;
        #1;
        vectors++;
        if (bus.lsu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_lsu_accept: got lsu_ready=%b, want 1", bus.lsu_ready);
        end
        @(posedge clk);
        #1;
        bus.lsu_valid = 0;
        vectors++;
        if (bus.w_enable !== 1'b0 || bus.busy !== 32'd0) begin
            miscompares++;
            $display("FAIL zero_lsu_write: got w_enable=%b busy=%h, want 0/0", bus.w_enable, bus.busy);
        end
        $display("test_zero_reg done");
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus.issue_valid = 1; bus.issue_rd = 3;
        @(posedge clk);
        #1;
        bus.issue_valid = 0;
        bus.lsu_valid = 1; bus.lsu_rd = 3; bus.lsu_data = 32'hCAFE_0003;
        #1;
        vectors++;
        if (bus.busy[3] !== 1'b1 || bus.lsu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_setup: got busy3=%b lsu_ready=%b, want 1/1", bus.busy[3], bus.lsu_ready);
        end
        @(posedge clk);
        #1;
        bus.lsu_valid = 0;
        vectors++;
        if (bus.w_enable !== 1'b1 || bus.rd_num !== 5'd3) begin
            miscompares++;
            $display("FAIL mid_write: got w_enable=%b rd_num=%0d, want 1/3", bus.w_enable, bus.rd_num);
        end
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.w_enable !== 1'b0 || bus.busy !== 32'd0 || bus.rd_num !== 5'd0 || bus.rd_data !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_async_reset: got w_enable=%b busy=%h rd_num=%0d rd_data=%h, want all 0",
                     bus.w_enable, bus.busy, bus.rd_num, bus.rd_data);
        end
        #2;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (bus.w_enable !== 1'b0 || bus.busy !== 32'd0) begin
                miscompares++;
                $display("FAIL mid_after_release[%0d]: got w_enable=%b busy=%h, want 0/0",
                         i, bus.w_enable, bus.busy);
            end
        end
        $display("test_reset_midflight done");
    endtask

    task automatic test_waw();
        do_reset();
        bus.issue_valid = 1; bus.issue_rd = 9;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (bus.issue_ready !== 1'b0 || bus.busy[9] !== 1'b1) begin
                miscompares++;
                $display("FAIL waw_stall[%0d]: got issue_ready=%b busy9=%b, want 0/1",
                         i, bus.issue_ready, bus.busy[9]);
            end
            @(posedge clk);
            #1;
        end
        bus.lsu_valid = 1; bus.lsu_rd = 9; bus.lsu_data = 32'h9999_9999;
        @(posedge clk);
        #1;
        bus.lsu_valid = 0;
        bus.issue_valid = 0;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.issue_ready !== 1'b1 || bus.busy[9] !== 1'b0) begin
            miscompares++;
            $display("FAIL waw_release: got issue_ready=%b busy9=%b, want 1/0", bus.issue_ready, bus.busy[9]);
        end
        $display("test_waw done");
    endtask

    task automatic test_random();
        bit exp_ir;
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            // Requesters hold until accepted; new requests only once the old one went.
            if (!bus.alu_valid && $urandom_range(0, 9) < 4) begin
                bus.alu_valid = 1; bus.alu_rd = 5'($urandom_range(0, 7)); bus.alu_data = $urandom;
            end
            if (!bus.lsu_valid && $urandom_range(0, 9) < 4) begin
                bus.lsu_valid = 1; bus.lsu_rd = 5'($urandom_range(0, 7)); bus.lsu_data = $urandom;
            end
            bus.issue_valid = ($urandom_range(0, 1) == 1);
            bus.issue_rd = 5'($urandom_range(0, 7));
            bus.rs1_num  = 5'($urandom_range(0, 7));
            bus.rs2_num  = 5'($urandom_range(0, 7));
            #1;
            exp_ir = model_issue_ready();
            vectors++;
            if (bus.alu_ready !== model_alu_wins() || bus.lsu_ready !== model_lsu_wins() ||
                bus.issue_ready !== exp_ir) begin
                miscompares++;
                $display("FAIL rand_comb[%0d]: got alu/lsu/issue_ready=%b%b%b, want %b%b%b",
                         cyc, bus.alu_ready, bus.lsu_ready, bus.issue_ready,
                         model_alu_wins(), model_lsu_wins(), exp_ir);
            end
            @(posedge clk);
            model_edge();
            #1;
            if (bus.alu_valid && bus.alu_ready) bus.alu_valid = 0;
            if (bus.lsu_valid && bus.lsu_ready) bus.lsu_valid = 0;
            vectors++;
            if (bus.w_enable !== m_wen || bus.rd_num !== m_rdn || bus.rd_data !== m_rdd || bus.busy !== m_busy) begin
                miscompares++;
                $display("FAIL rand_edge[%0d]: got wen=%b rd=%0d data=%h busy=%h, want wen=%b rd=%0d data=%h busy=%h",
                         cyc, bus.w_enable, bus.rd_num, bus.rd_data, bus.busy, m_wen, m_rdn, m_rdd, m_busy);
            end
        end
        idle_inputs();
        $display("test_random done");
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        idle_inputs();
        rst = 1'b0;
        test_reset();
        test_single_alu();
        test_round_robin();
        test_raw();
        test_zero_reg();
        test_reset_midflight();
        test_waw();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_scheduler.md
WB_SCHEDULER -- requirements
Module: wb_scheduler

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter NREG, default 32, register count; register index width is 5.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port issue_valid  input  1  decoder presents an instruction for issue.
REQ-006 SHALL have port issue_rd  input  5  destination register of the issuing instruction.
REQ-007 SHALL have port rs1_num / rs2_num  input  5 each  source registers of the issuing instruction.
REQ-008 SHALL have port issue_ready  output  1  no hazard; issue fires on issue_valid & issue_ready.
REQ-009 SHALL have port alu_valid / alu_rd / alu_data  input  1 / 5 / XLEN  ALU writeback request.
REQ-010 SHALL have port alu_ready  output  1  ALU request accepted this cycle.
REQ-011 SHALL have port lsu_valid / lsu_rd / lsu_data  input  1 / 5 / XLEN  load-unit writeback request.
REQ-012 SHALL have port lsu_ready  output  1  LSU request accepted this cycle.
REQ-013 SHALL have port w_enable / rd_num / rd_data  output  1 / 5 / XLEN  registered regfile write port.
REQ-014 SHALL have port busy  output  NREG  scoreboard, bit r set = write to r pending.

Function
REQ-015 SHALL grant at most one requester per cycle; alu_ready and lsu_ready are combinational from the valids and the last-grant state, and are never both 1.
REQ-016 SHALL arbitrate round-robin: with both valid, grant the requester not granted last; with one valid, grant it immediately.
REQ-017 SHALL update the last-grant register only on an accepted transfer (valid & ready).
REQ-018 SHALL register the granted request into w_enable/rd_num/rd_data on the acceptance edge; write latency is exactly 1 cycle, throughput 1 write per cycle.
REQ-019 SHALL drive w_enable=0 in any cycle following a cycle with no accepted transfer; rd_num/rd_data then hold their last values.
REQ-020 SHALL accept a transfer with rd=0 but drive w_enable=0 for it.
REQ-021 SHALL hold busy[0]=0 permanently.
REQ-022 SHALL set busy[issue_rd] on the edge where issue fires and issue_rd!=0.
REQ-023 SHALL clear busy[rd_num] on the edge ending a cycle with w_enable=1, i.e. the same edge the regfile commits the write.
REQ-024 SHALL give set priority over clear if both target the same register on one edge.
REQ-025 SHALL compute issue_ready = 0 when busy[rs1_num], busy[rs2_num] or busy[issue_rd] is set for a nonzero index (RAW and WAW); otherwise 1, independent of issue_valid.
REQ-026 SHALL let a dependent instruction issue the cycle after the clearing edge, reading the committed value combinationally from the regfile.
REQ-027 SHALL require requesters to hold valid, rd and data stable until accepted; behaviour otherwise is undefined.

Reset
REQ-028 SHALL, while rst=1, force busy=0, w_enable=0, rd_num=0, rd_data=0, last-grant=LSU (ALU wins first contention), asynchronously.
REQ-029 SHALL discard any in-flight write on reset mid-operation; no write is emitted after rst deasserts until a new transfer is accepted.

Verification
REQ-030 SHALL pass: reset, then alu_valid=1 rd=5 data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle w_enable=1 rd_num=5 rd_data=0xDEADBEEF.
REQ-031 SHALL pass: alu and lsu valid together for 4 cycles, rd 1 and 2 -> grants ALU, LSU, ALU, LSU; w_enable rd_num 1,2,1,2 one cycle later.
REQ-032 SHALL pass: issue rd=7, next cycle rs1=7 -> issue_ready=0 until the edge ending the w_enable=1 rd_num=7 cycle, then 1; busy[7] 1 then 0.
REQ-033 SHALL pass: issue rd=0, rs1=0 repeatedly -> issue_ready stays 1, busy stays 0; lsu writeback rd=0 -> lsu_ready=1, w_enable=0.
REQ-034 SHALL pass: busy[3]=1, lsu request rd=3 accepted, rst asserted during the w_enable=1 cycle -> w_enable=0, busy=0 immediately; no write after release.
REQ-035 SHALL pass: busy[9]=1, issue_rd=9 -> issue_ready=0 (WAW) until busy[9] clears.
